// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared integer register-file constants, also used by regfile_int and decode.
package regfile_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam logic [AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO for buffered load results; count-based full/empty, push and pop may coincide.
module wb_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writer: arbitrates ALU and buffered load results onto the single write port
// and keeps the per-register pending scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter #(
  parameter int XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int AW = regfile_wb_arbiter_pkg::AW,
  parameter int LD_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            hz_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            alu_stall,
  output logic [AW-1:0]   wa1,
  output logic [XLEN-1:0] wd1,
  output logic            we,
  output logic            err_proto
);
  import regfile_wb_arbiter_pkg::*;

  localparam int SW = $clog2(STARVE_MAX) + 1;

  logic [NREG-1:0]    pend;
  logic [NREG-1:0]    pend_nxt;
  logic [SW-1:0]      starve;
  logic               ld_full;
  logic               ld_empty;
  logic               ld_push;
  logic               ld_pop;
  logic [AW+XLEN-1:0] ld_head;
  wb_src_e            src;
  logic [AW-1:0]      win_rd;
  logic [XLEN-1:0]    win_data;
  logic               win_we;

  // Valid/ready: a transfer happens in any cycle where both are high; the ALU
  // side has no ready and is instead throttled through the registered alu_stall.
  assign iss_ready = !iss_valid || !pend[iss_rd];
  assign hz_stall  = pend[iss_rs1] | pend[iss_rs2];
  assign ld_ready  = !ld_full;
  assign ld_push   = ld_valid && ld_ready;

  wb_fifo #(
    .W    (AW + XLEN),
    .DEPTH(LD_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (ld_push),
    .din  ({ld_rd, ld_data}),
    .pop  (ld_pop),
    .dout (ld_head),
    .full (ld_full),
    .empty(ld_empty)
  );

  // An ALU result arriving while alu_stall is high is a protocol error and is dropped.
  always_comb begin
    src      = SRC_NONE;
    win_rd   = REG_X0;
    win_data = '0;
    if (alu_stall && !ld_empty)      src = SRC_LD;
    else if (alu_valid && !alu_stall) src = SRC_ALU;
    else if (!ld_empty)               src = SRC_LD;
    case (src)
      SRC_ALU: begin
        win_rd   = alu_rd;
        win_data = alu_data;
      end
      SRC_LD:  {win_rd, win_data} = ld_head;
      default: ;
    endcase
  end

  assign ld_pop = (src == SRC_LD);
  assign win_we = (src != SRC_NONE) && (win_rd != REG_X0);

  // Commit clears the pending bit on the same edge the register file writes; a new issue wins.
  always_comb begin
    pend_nxt = pend;
    if (we) pend_nxt[wa1] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != REG_X0)) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      starve    <= '0;
      alu_stall <= 1'b0;
      err_proto <= 1'b0;
      we        <= 1'b0;
      wa1       <= '0;
      wd1       <= '0;
    end else begin
      pend <= pend_nxt;
      if (alu_valid && alu_stall) err_proto <= 1'b1;
      if (ld_pop) begin
        starve    <= '0;
        alu_stall <= 1'b0;
      end else if ((src == SRC_ALU) && !ld_empty) begin
        starve <= starve + SW'(1);
        if (starve == SW'(STARVE_MAX - 1)) alu_stall <= 1'b1;
      end
      we <= win_we;
      if (win_we) begin
        wa1 <= win_rd;
        wd1 <= win_data;
      end
    end
  end
endmodule
